// File: rtl/rr_arb_pkg.sv
// Shared types and helper functions for the parametrised round-robin arbiter.
// Functions operate on the widest legal vector (32 requesters) and are narrowed by callers.
package rr_arb_pkg;

  localparam int unsigned MAX_REQ   = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req searching upward from start, wrapping at n-1 -> 0.
  function automatic pick_t first_set_from(input logic [MAX_REQ-1:0]   req,
                                           input logic [MAX_IDX_W-1:0] start,
                                           input int unsigned          n);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = 32'(start) + k;
        if (j >= n) j = j - n;
        if (!r.found && req[j]) begin
          r.found = 1'b1;
          r.idx   = MAX_IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational circular priority pick: winner index and found flag for a request
// vector, searching from the given pointer.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  pick_t w_pick;

  always_comb begin
    w_pick  = first_set_from(MAX_REQ'(i_req), MAX_IDX_W'(i_ptr), NUM_REQ);
    o_idx   = w_pick.idx[IDX_W-1:0];
    o_found = w_pick.found;
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with registered one-hot grant, tenure limit and
// zero-bubble re-arbitration on release.
module rr_arbiter_param
  import rr_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned MAX_HOLD = 4,
  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               arb_clk,
  input  logic               arb_rst_n,
  input  logic [NUM_REQ-1:0] arb_req,
  input  logic               arb_release,
  output logic [NUM_REQ-1:0] arb_gnt,
  output logic               arb_gnt_valid,
  output logic [IDX_W-1:0]   arb_gnt_idx,
  output logic [IDX_W-1:0]   pointer,
  output logic               arb_preempt
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [IDX_W-1:0]    r_gnt_idx;
  logic [IDX_W-1:0]    r_ptr;
  logic                r_preempt;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic                w_rel_a;
  logic                w_rel_b;
  logic                w_rel_c;
  logic                w_release;
  logic                w_hold_sat;
  logic [IDX_W-1:0]    w_next_ptr;
  logic [IDX_W-1:0]    w_pick_ptr;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_found;
  logic [MAX_REQ-1:0]  w_onehot;

  always_comb begin
    w_rel_a    = ~arb_req[r_gnt_idx];
    w_rel_b    = arb_release;
    w_rel_c    = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_W'(MAX_HOLD));
    w_release  = w_rel_a | w_rel_b | w_rel_c;
    w_hold_sat = (r_hold_cnt == '1) ||
                 ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_W'(MAX_HOLD)));
    w_next_ptr = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
    // While granting, the pick already sees the post-release pointer so a
    // release can hand over in the same edge; the old holder searches last.
    w_pick_ptr = (r_state == GRANT) ? w_next_ptr : r_ptr;
    w_onehot   = idx_to_onehot(MAX_IDX_W'(w_pick_idx));
  end

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (arb_req),
    .i_ptr   (w_pick_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_ptr      <= '0;
      r_preempt  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= GRANT;
            r_gnt      <= w_onehot[NUM_REQ-1:0];
            r_gnt_idx  <= w_pick_idx;
            r_hold_cnt <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr     <= w_next_ptr;
            r_preempt <= w_rel_c & ~w_rel_a & ~w_rel_b;
            if (w_found) begin
              r_gnt      <= w_onehot[NUM_REQ-1:0];
              r_gnt_idx  <= w_pick_idx;
              r_hold_cnt <= HOLD_W'(1);
            end else begin
              r_state    <= IDLE;
              r_gnt      <= '0;
              r_gnt_idx  <= '0;
              r_hold_cnt <= '0;
            end
          end else if (!w_hold_sat) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arb_gnt       = r_gnt;
  assign arb_gnt_valid = (r_state == GRANT);
  assign arb_gnt_idx   = r_gnt_idx;
  assign pointer       = r_ptr;
  assign arb_preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Scoreboard bench for rr_arbiter_param (NUM_REQ=4, MAX_HOLD=4): a driver pushes
// model predictions, a monitor pops and compares after each rising edge.
`timescale 1ns/100ps
module tb_rr_arbiter_param;

  localparam int N = 4;
  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [1:0] ptr;
  logic       preempt;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic [1:0] ptr;
    logic       pre;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state: holder -1 means idle
  int m_holder;
  int m_ptr;
  int m_cnt;

  rr_arbiter_param #(
    .NUM_REQ  (N),
    .MAX_HOLD (H)
  ) dut (
    .arb_clk       (clk),
    .arb_rst_n     (rst_n),
    .arb_req       (req),
    .arb_release   (rel),
    .arb_gnt       (gnt),
    .arb_gnt_valid (gnt_valid),
    .arb_gnt_idx   (gnt_idx),
    .pointer       (ptr),
    .arb_preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tb_pick(input logic [3:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_cnt    = 0;
  endtask

  // Predict the outputs after the coming edge and hand them to the scoreboard.
  task automatic apply(input logic [3:0] r, input logic rl);
    exp_t e;
    int   w;
    bit   a, b, c;
    req = r;
    rel = rl;
    e.pre = 1'b0;
    if (m_holder < 0) begin
      w = tb_pick(r, m_ptr);
      if (w >= 0) begin
        m_holder = w;
        m_cnt    = 1;
      end
    end else begin
      a = !r[m_holder];
      b = rl;
      c = (H != 0) && (m_cnt == H);
      if (a || b || c) begin
        e.pre = c && !a && !b;
        m_ptr = (m_holder + 1) % N;
        w = tb_pick(r, m_ptr);
        m_holder = w;
        m_cnt    = (w >= 0) ? 1 : 0;
      end else begin
        m_cnt++;
      end
    end
    e.gnt = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0000;
    e.idx = (m_holder >= 0) ? 2'(m_holder) : 2'd0;
    e.ptr = 2'(m_ptr);
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic rl);
    @(negedge clk);
    apply(r, rl);
  endtask

  // Monitor: compares the outputs of each edge against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt",       32'(gnt),       32'(e.gnt));
        chk("gnt_valid", 32'(gnt_valid), 32'(e.gnt != 4'b0000));
        chk("gnt_idx",   32'(gnt_idx),   32'(e.idx));
        chk("pointer",   32'(ptr),       32'(e.ptr));
        chk("preempt",   32'(preempt),   32'(e.pre));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b1111;
    rel   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",     32'(gnt),       32'd0);
    chk("rst_valid",   32'(gnt_valid), 32'd0);
    chk("rst_idx",     32'(gnt_idx),   32'd0);
    chk("rst_pointer", 32'(ptr),       32'd0);
    chk("rst_preempt", 32'(preempt),   32'd0);

    // release reset under full load, then 20 cycles of full rotation
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b1111, 1'b0);
    repeat (20) step(4'b1111, 1'b0);

    // single requester, then drop
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // forced release with another requester waiting
    step(4'b0001, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b0);

    // sole requester 3 through a tenure expiry and pointer wrap
    repeat (8) step(4'b1000, 1'b0);

    // release pulse while idle is ignored
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // randomized traffic
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 9) == 0));
    end

    // async reset while requester 1 holds the grant
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    @(posedge clk);
    #3;
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("async_gnt",     32'(gnt),       32'd0);
    chk("async_valid",   32'(gnt_valid), 32'd0);
    chk("async_idx",     32'(gnt_idx),   32'd0);
    chk("async_pointer", 32'(ptr),       32'd0);
    chk("async_preempt", 32'(preempt),   32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b0110, 1'b0);
    r = 4'b0110;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
Parametrised N-way round-robin arbiter with a one-hot registered grant. A grant is held while the winner keeps requesting, up to a configurable tenure limit. After the grant is released or pre-empted, the arbiter re-arbitrates with no idle cycle. It replaces the fixed 4-way, pointer-per-cycle arbiter in front of shared resources (bus ports, memory banks), and gives a provable starvation bound.

Parameters:
NUM_REQ, 4, number of requesters; legal range 1..32.
MAX_HOLD, 4, maximum consecutive grant cycles per tenure; 0 disables the tenure limit.
IDX_W, max(1,$clog2(NUM_REQ)), width of index outputs (derived, not overridden).

Ports:
arb_clk  input  1  single clock, rising edge
arb_rst_n  input  1  asynchronous active-low reset
arb_req  input  NUM_REQ  request vector; bit i = requester i
arb_release  input  1  one-cycle pulse; current holder yields at this edge
arb_gnt  output  NUM_REQ  one-hot grant (all-zero when idle), registered
arb_gnt_valid  output  1  high while arb_gnt is non-zero
arb_gnt_idx  output  IDX_W  binary index of the granted requester; 0 when idle
pointer  output  IDX_W  highest-priority index for the next arbitration
arb_preempt  output  1  one-cycle pulse when the tenure limit forced the release

Behaviour:
- Reset (async assert, sync-to-clock deassert by the integrator): state=IDLE; arb_gnt=0, arb_gnt_valid=0, arb_gnt_idx=0, pointer=0, arb_preempt=0, hold_cnt=0. Reset mid-grant drops the grant immediately.
- Pick function: winner = first set bit of arb_req, searching circularly from pointer upward with wrap at NUM_REQ-1 -> 0.
- FSM with 2 states, IDLE and GRANT:
  - IDLE: if |arb_req, the next edge registers arb_gnt=onehot(winner), arb_gnt_idx=winner, valid=1, hold_cnt=1, and moves to GRANT. Latency is 1 cycle from the sampled request to the grant. If no request, stay in IDLE; pointer is unchanged.
  - GRANT: release occurs when any of these holds:
    - (a) arb_req[holder]==0;
    - (b) arb_release==1;
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
  - No release: keep the grant and increment hold_cnt (saturating at MAX_HOLD).
  - Release: pointer <= (holder+1) mod NUM_REQ. In the same edge, re-pick using the updated pointer against the current arb_req.
    - A requester found: grant it with hold_cnt=1 and no bubble.
    - None found: go to IDLE with arb_gnt=0.
  - The former holder has lowest priority in the re-pick. It wins only if it is the sole requester.
- arb_preempt=1 for exactly one cycle, the cycle after the edge at which cause (c) fired and neither (a) nor (b) was true.
- Invariants:
  - $onehot0(arb_gnt) always holds.
  - arb_gnt_valid == |arb_gnt.
  - arb_gnt[i] implies arb_req[i] was high at the previous edge.
- Starvation bound (MAX_HOLD=H>0): a continuously held request is granted within (NUM_REQ-1)*H+1 cycles.
- NUM_REQ=1: pointer stays 0; the grant follows the request with 1-cycle latency, subject to the tenure limit.
- arb_release while IDLE is ignored.

Decomposition:
- Package rr_arb_pkg holds:
  - the state typedef (IDLE, GRANT);
  - a function for circular first-set index from a start pointer;
  - a function for index-to-one-hot.
- One combinational sub-module, rr_arb_pick, takes req vector and pointer and returns winner index and found flag. It is instantiated once in the arbiter.

Test Plan:
- Reset: hold arb_rst_n=0 with arb_req=4'b1111 -> arb_gnt=0, valid=0, pointer=0. Release reset -> first grant 4'b0001 one cycle later.
- Full load, MAX_HOLD=4, arb_req=4'b1111 held -> grant sequence:
  - 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001 again;
  - arb_preempt pulses at each switch;
  - there are no idle cycles between tenures.
- Single requester: pointer=0, arb_req=4'b0100 for 2 cycles, then 0 -> gnt=0100 for 2 cycles, then 0. pointer=3 after the release, state IDLE.
- Forced release: holder=0 with arb_req=4'b1001; pulse arb_release -> next gnt=1000, pointer=1, arb_preempt=0.
- Wrap plus sole requester: holder=3, preempted, with only arb_req[3] set -> gnt stays 1000 (new tenure, hold_cnt=1) and pointer=0.
- Async reset mid-grant: assert arb_rst_n low between clock edges while gnt=0010 -> all outputs 0 immediately, before the next edge.
